// File: rtl/key_arb_pkg.sv
// key_arb_pkg: shared state type, widths and key-whitening function for key_session_arbiter
package key_arb_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, SCRUB} state_e;
  localparam int KEY_W = 32;
  localparam int DATA_W = 8;
  localparam int CNT_W = 4;
  function automatic logic [KEY_W-1:0] whiten(input logic [KEY_W-1:0] key, input logic [DATA_W-1:0] data);
    return key ^ {{(KEY_W-DATA_W){1'b0}}, data};
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin pick, searching upward from the requester after last_i
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int PW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PW-1:0]      last_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o
);
  logic [PW-1:0] idx;
  always_comb begin
    gnt_o = '0;
    idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = PW'((int'(last_i) + k) % NUM_REQ);
      if (en_i && req_i[idx]) gnt_o = NUM_REQ'(1) << idx;
    end
  end
endmodule

// File: rtl/key_session_arbiter.sv
// key_session_arbiter: round-robin sessions on one XOR key-whitening engine, zeroizing scrub after each; KEY_SCRUB_CHECK_EN adds sticky scrub_err
module key_session_arbiter
  import key_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int MAX_USES = 5,
  parameter int SCRUB_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*KEY_W-1:0] key_flat,
  input  logic [DATA_W-1:0]        din,
  input  logic                     din_valid,
  input  logic                     din_last,
  output logic                     din_ready,
  output logic [KEY_W-1:0]         dout,
  output logic                     dout_valid,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [CNT_W-1:0]         use_count,
`ifdef KEY_SCRUB_CHECK_EN
  output logic                     scrub_err,
`endif
  output logic                     scrub_active
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int SW = $clog2(SCRUB_CYCLES + 1);
  state_e state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, arb_gnt;
  logic [PW-1:0] last_q, last_d, win;
  logic [KEY_W-1:0] key_q, key_d, dout_q, dout_d, slot;
  logic dv_q, dv_d, accept, scrub_last;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SW-1:0] sc_q, sc_d;
`ifdef KEY_SCRUB_CHECK_EN
  logic err_q, err_d;
`endif
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i (req),
    .last_i(last_q),
    .en_i  (state_q == IDLE),
    .gnt_o (arb_gnt)
  );
  // last_q doubles as the granted index from LOAD until the next grant
  always_comb begin
    win = '0;
    slot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) win = PW'(i);
      if (last_q == PW'(i)) slot = key_flat[i*KEY_W +: KEY_W];
    end
  end
  assign accept = din_valid && din_ready;
  assign scrub_last = state_q == SCRUB && sc_q == SW'(SCRUB_CYCLES - 1);
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    last_d = last_q;
    key_d = key_q;
    cnt_d = cnt_q;
    sc_d = sc_q;
    dout_d = accept ? whiten(key_q, din) : '0;
    dv_d = accept;
`ifdef KEY_SCRUB_CHECK_EN
    err_d = err_q;
`endif
    if (state_q == IDLE && |arb_gnt) begin
      state_d = LOAD;
      gnt_d = arb_gnt;
      last_d = win;
    end
    if (state_q == LOAD) begin
      state_d = RUN;
      key_d = slot;
    end
    if (state_q == RUN) begin
      cnt_d = cnt_q + CNT_W'(accept);
      if (!req[last_q] || (accept && (din_last || cnt_q == CNT_W'(MAX_USES - 1)))) begin
        state_d = SCRUB;
        gnt_d = '0;
        key_d = '0;
        sc_d = '0;
      end
    end
    // the final count stays visible for the first SCRUB cycle, then clears
    if (state_q == SCRUB) begin
      cnt_d = '0;
      state_d = scrub_last ? IDLE : SCRUB;
      sc_d = scrub_last ? sc_q : sc_q + 1'b1;
`ifdef KEY_SCRUB_CHECK_EN
      // a last-beat pulse may still be on dout when SCRUB_CYCLES is 1
      err_d = err_q || (scrub_last && (|key_q || (|dout_q && !dv_q)));
      if (err_d) state_d = SCRUB;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q <= '0;
      last_q <= PW'(NUM_REQ - 1);
      key_q <= '0;
      dout_q <= '0;
      dv_q <= 1'b0;
      cnt_q <= '0;
      sc_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      last_q <= last_d;
      key_q <= key_d;
      dout_q <= dout_d;
      dv_q <= dv_d;
      cnt_q <= cnt_d;
      sc_q <= sc_d;
    end
  end
`ifdef KEY_SCRUB_CHECK_EN
  always_ff @(posedge clk) begin
    err_q <= rst ? 1'b0 : err_d;
  end
  assign scrub_err = err_q;
`endif
  assign din_ready = state_q == RUN;
  assign dout = dout_q;
  assign dout_valid = dv_q;
  assign gnt = gnt_q;
  assign use_count = cnt_q;
  assign scrub_active = state_q == SCRUB;
endmodule

// File: tb/tb_key_session_arbiter.sv
// tb_key_session_arbiter: vector table, corner sequences and randomized reference-model check of key_session_arbiter
module tb_key_session_arbiter;
  import key_arb_pkg::*;
  localparam int N = 4;
  localparam int MU = 5;
  localparam int SC = 2;
  typedef struct {
    logic r; logic [3:0] rq; logic v; logic l;
    logic [3:0] eg; logic er; logic ev; logic [31:0] ed; logic [3:0] ec; logic es; logic [31:0] ek;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req = '0;
  logic [31:0] keys [4];
  logic [127:0] key_flat;
  logic [7:0] din = '0;
  logic din_valid = 1'b0;
  logic din_last = 1'b0;
  logic din_ready, dout_valid, scrub_active;
  logic [31:0] dout;
  logic [3:0] gnt, use_count;
`ifdef KEY_SCRUB_CHECK_EN
  logic scrub_err;
`endif
  int n_cmp = 0;
  int n_bad = 0;
  bit m_busy = 0, m_loaded = 0, m_dv = 0;
  logic [1:0] m_owner = '0, m_last = 2'd3;
  logic [3:0] m_uses = '0;
  int m_scrub = 0;
  logic [31:0] m_key = '0, m_dout = '0;
  assign key_flat = {keys[3], keys[2], keys[1], keys[0]};
  always #5 clk = ~clk;
  key_session_arbiter #(.NUM_REQ(N), .MAX_USES(MU), .SCRUB_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .req(req), .key_flat(key_flat), .din(din),
    .din_valid(din_valid), .din_last(din_last), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .gnt(gnt), .use_count(use_count),
`ifdef KEY_SCRUB_CHECK_EN
    .scrub_err(scrub_err),
`endif
    .scrub_active(scrub_active)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  // session-level reference: owner/loaded/scrub countdown, applied at each rising edge
  task automatic model_step();
    bit acc, found;
    logic [1:0] i;
    logic [31:0] nd;
    if (rst) begin
      m_busy = 0; m_loaded = 0; m_dv = 0; m_owner = '0; m_last = 2'd3;
      m_uses = '0; m_scrub = 0; m_key = '0; m_dout = '0;
      return;
    end
    acc = m_busy && m_loaded && din_valid;
    nd = acc ? (m_key ^ {24'h0, din}) : 32'h0;
    if (m_scrub > 0) begin
      m_uses = '0;
      m_scrub--;
    end else if (!m_busy) begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        i = m_last + 2'(k);
        if (!found && req[i]) begin found = 1; m_owner = i; end
      end
      if (found) begin m_busy = 1; m_loaded = 0; m_last = m_owner; end
    end else if (!m_loaded) begin
      m_loaded = 1;
      m_key = keys[m_owner];
    end else begin
      if (acc) m_uses++;
      if (!req[m_owner] || (acc && (din_last || m_uses == 4'(MU)))) begin
        m_busy = 0; m_loaded = 0; m_key = '0; m_scrub = SC;
      end
    end
    m_dout = nd;
    m_dv = acc;
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask
  task automatic check_model();
    logic [3:0] eg;
    eg = '0;
    if (m_busy) eg[m_owner] = 1'b1;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("din_ready", 32'(din_ready), 32'(m_busy && m_loaded));
    chk("dout", dout, m_dout);
    chk("dout_valid", 32'(dout_valid), 32'(m_dv));
    chk("use_count", 32'(use_count), 32'(m_uses));
    chk("scrub_active", 32'(scrub_active), 32'(m_scrub > 0));
    chk("key_reg", dut.key_q, m_key);
`ifdef KEY_SCRUB_CHECK_EN
    chk("scrub_err", 32'(scrub_err), 32'h0);
`endif
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    vec_t tv [13];
    logic [3:0] seen [$];
    logic [3:0] rr_exp [3];
    logic [3:0] prev;
    keys[0] = 32'hDEADBEEF; keys[1] = 32'h01234567; keys[2] = 32'hCAFEF00D; keys[3] = 32'h89ABCDEF;
    rr_exp = '{4'b0010, 4'b1000, 4'b0010};
    tv[0]  = '{1'b1, 4'hF, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 32'h0,        4'd0, 1'b0, 32'h0};
    tv[1]  = '{1'b1, 4'hF, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 32'h0,        4'd0, 1'b0, 32'h0};
    tv[2]  = '{1'b0, 4'h1, 1'b1, 1'b0, 4'h1, 1'b0, 1'b0, 32'h0,        4'd0, 1'b0, 32'h0};
    tv[3]  = '{1'b0, 4'h1, 1'b1, 1'b0, 4'h1, 1'b1, 1'b0, 32'h0,        4'd0, 1'b0, 32'hDEADBEEF};
    tv[4]  = '{1'b0, 4'h1, 1'b1, 1'b0, 4'h1, 1'b1, 1'b1, 32'hDEADBEFE, 4'd1, 1'b0, 32'hDEADBEEF};
    tv[5]  = '{1'b0, 4'h1, 1'b1, 1'b0, 4'h1, 1'b1, 1'b1, 32'hDEADBEFE, 4'd2, 1'b0, 32'hDEADBEEF};
    tv[6]  = '{1'b0, 4'h1, 1'b1, 1'b0, 4'h1, 1'b1, 1'b1, 32'hDEADBEFE, 4'd3, 1'b0, 32'hDEADBEEF};
    tv[7]  = '{1'b0, 4'h1, 1'b1, 1'b0, 4'h1, 1'b1, 1'b1, 32'hDEADBEFE, 4'd4, 1'b0, 32'hDEADBEEF};
    tv[8]  = '{1'b0, 4'h1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 32'hDEADBEFE, 4'd5, 1'b1, 32'h0};
    tv[9]  = '{1'b0, 4'h1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 32'h0,        4'd0, 1'b1, 32'h0};
    tv[10] = '{1'b0, 4'h1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 32'h0,        4'd0, 1'b0, 32'h0};
    tv[11] = '{1'b0, 4'h1, 1'b1, 1'b0, 4'h1, 1'b0, 1'b0, 32'h0,        4'd0, 1'b0, 32'h0};
    tv[12] = '{1'b1, 4'h1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 32'h0,        4'd0, 1'b0, 32'h0};
    for (int t = 0; t < 13; t++) begin
      rst = tv[t].r; req = tv[t].rq; din = 8'h11; din_valid = tv[t].v; din_last = tv[t].l;
      tick();
      chk($sformatf("v%0d.gnt", t), 32'(gnt), 32'(tv[t].eg));
      chk($sformatf("v%0d.din_ready", t), 32'(din_ready), 32'(tv[t].er));
      chk($sformatf("v%0d.dout_valid", t), 32'(dout_valid), 32'(tv[t].ev));
      chk($sformatf("v%0d.dout", t), dout, tv[t].ed);
      chk($sformatf("v%0d.use_count", t), 32'(use_count), 32'(tv[t].ec));
      chk($sformatf("v%0d.scrub_active", t), 32'(scrub_active), 32'(tv[t].es));
      chk($sformatf("v%0d.key_reg", t), dut.key_q, tv[t].ek);
    end
    rst = 1; tick(); rst = 0;
    req = 4'b1010; din_valid = 1; din_last = 1; prev = '0;
    for (int c = 0; c < 40 && seen.size() < 3; c++) begin
      din = 8'($urandom);
      tick();
      check_model();
      if (gnt != 4'h0 && prev == 4'h0) seen.push_back(gnt);
      prev = gnt;
    end
    chk("rr.count", 32'(seen.size()), 32'd3);
    for (int g = 0; g < 3; g++)
      chk($sformatf("rr.gnt%0d", g), 32'(g < seen.size() ? seen[g] : 4'h0), 32'(rr_exp[g]));
    rst = 1; tick(); rst = 0;
    req = 4'b0100; din = 8'h5A; din_valid = 1; din_last = 0;
    repeat (4) tick();
    chk("drop.use_count_pre", 32'(use_count), 32'd2);
    req = 4'b0000;
    tick();
    chk("drop.dout_valid", 32'(dout_valid), 32'd1);
    chk("drop.dout", dout, 32'hCAFEF057);
    chk("drop.use_count", 32'(use_count), 32'd3);
    chk("drop.gnt", 32'(gnt), 32'h0);
    chk("drop.scrub_active", 32'(scrub_active), 32'd1);
    tick();
    chk("drop.use_count_clr", 32'(use_count), 32'd0);
    chk("drop.dout_clr", dout, 32'h0);
    chk("drop.key_reg", dut.key_q, 32'h0);
    rst = 1; tick(); rst = 0;
    req = 4'b0001; din_valid = 1; din_last = 0;
    repeat (4) tick();
    chk("mrst.use_count_pre", 32'(use_count), 32'd2);
    rst = 1;
    tick();
    chk("mrst.gnt", 32'(gnt), 32'h0);
    chk("mrst.dout", dout, 32'h0);
    chk("mrst.dout_valid", 32'(dout_valid), 32'h0);
    chk("mrst.din_ready", 32'(din_ready), 32'h0);
    chk("mrst.use_count", 32'(use_count), 32'h0);
    chk("mrst.scrub_active", 32'(scrub_active), 32'h0);
    chk("mrst.state", 32'(dut.state_q), 32'(IDLE));
    tick();
    chk("mrst.no_scrub", 32'(scrub_active), 32'h0);
    rst = 0; req = '0;
    for (int c = 0; c < 3000; c++) begin
      rst = $urandom_range(0, 249) == 0;
      if ($urandom_range(0, 7) == 0) req = 4'($urandom);
      din = 8'($urandom);
      din_valid = $urandom_range(0, 3) != 0;
      din_last = $urandom_range(0, 5) == 0;
      if (c == 1500) for (int k = 0; k < 4; k++) keys[k] = $urandom;
      tick();
      check_model();
    end
`ifdef KEY_SCRUB_CHECK_EN
    rst = 1; tick(); rst = 0;
    req = 4'b0001; din_valid = 1; din_last = 1;
    for (int c = 0; c < 10 && !scrub_active; c++) tick();
    chk("err.enter", 32'(scrub_active), 32'd1);
    force dut.key_q = 32'h1;
    tick();
    release dut.key_q;
    tick();
    chk("err.flag", 32'(scrub_err), 32'd1);
    req = 4'hF;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("err.no_gnt", 32'(gnt), 32'h0);
    end
    rst = 1; tick(); rst = 0;
    chk("err.clear", 32'(scrub_err), 32'h0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
